param_ping_pong_counter: RTL and testbench

PARAM_PING_PONG_COUNTER -- requirements
Module: param_ping_pong_counter

---
 rtl/ppc_pkg.sv | 14 +
 rtl/ppc_step_unit.sv | 25 ++
 rtl/param_ping_pong_counter.sv | 125 ++++++++++++
 tb/tb_param_ping_pong_counter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ppc_pkg.sv
// Shared constants for the ping-pong counter: mode encodings and direction type.
package ppc_pkg;

  localparam logic [1:0] MODE_PINGPONG = 2'b00;
  localparam logic [1:0] MODE_WRAP     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT  = 2'b10;
  localparam logic [1:0] MODE_HOLD     = 2'b11;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage

// File: rtl/ppc_step_unit.sv
// Saturating up/down step: one guard bit keeps out+step and out-step from wrapping,
// results are clamped into [lo, hi].
module ppc_step_unit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] up_next,
  output logic [WIDTH-1:0] down_next
);

  logic [WIDTH:0] sum_w;
  logic [WIDTH:0] dif_w;

  always_comb begin
    sum_w = {1'b0, out} + {1'b0, step};
    dif_w = {1'b0, out} - {1'b0, step};
    up_next   = (sum_w > {1'b0, hi}) ? hi : sum_w[WIDTH-1:0];
    // top bit of dif_w set means the subtraction borrowed past zero
    down_next = (dif_w[WIDTH] || (dif_w < {1'b0, lo})) ? lo : dif_w[WIDTH-1:0];
  end

endmodule

// File: rtl/param_ping_pong_counter.sv
// Bounded up/down counter with ping-pong, wrap, one-shot and hold modes,
// synchronous load and range correction when out drifts outside [lo, hi].
module param_ping_pong_counter
  import ppc_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             load_dir,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] step,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] out,
  output logic             direction,
  output logic             bounce,
  output logic             done,
  output logic             cfg_err
);

  dir_e             dir_q;
  dir_e             dir_nxt;
  logic [WIDTH-1:0] out_nxt;
  logic             bounce_nxt;
  logic             done_nxt;
  logic [WIDTH-1:0] up_next;
  logic [WIDTH-1:0] down_next;

  ppc_step_unit #(.WIDTH(WIDTH)) u_step (
    .out       (out),
    .step      (step),
    .lo        (lo),
    .hi        (hi),
    .up_next   (up_next),
    .down_next (down_next)
  );

  assign cfg_err   = (lo > hi) || (step == '0);
  assign direction = dir_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out    <= '0;
      dir_q  <= DIR_UP;
      bounce <= 1'b0;
      done   <= 1'b0;
    end else begin
      out    <= out_nxt;
      dir_q  <= dir_nxt;
      bounce <= bounce_nxt;
      done   <= done_nxt;
    end
  end

  // Once the range checks pass, out sits exactly on hi (or lo) whenever the
  // ">= hi" / "<= lo" turn conditions fire, so the step unit's down_next/up_next
  // already equal max(hi-step, lo) / min(lo+step, hi) for the reversal.
  always_comb begin
    out_nxt    = out;
    dir_nxt    = dir_q;
    done_nxt   = done;
    bounce_nxt = 1'b0;
    if (load) begin
      out_nxt  = load_val;
      dir_nxt  = load_dir ? DIR_UP : DIR_DOWN;
      done_nxt = 1'b0;
    end else if (enable && !cfg_err) begin
      if (out > hi) begin
        out_nxt = hi;
      end else if (out < lo) begin
        out_nxt = lo;
      end else begin
        case (mode)
          MODE_PINGPONG: begin
            if (dir_q == DIR_UP) begin
              if (out >= hi) begin
                dir_nxt    = DIR_DOWN;
                out_nxt    = down_next;
                bounce_nxt = 1'b1;
              end else begin
                out_nxt = up_next;
              end
            end else begin
              if (out <= lo) begin
                dir_nxt    = DIR_UP;
                out_nxt    = up_next;
                bounce_nxt = 1'b1;
              end else begin
                out_nxt = down_next;
              end
            end
          end
          MODE_WRAP: begin
            if (dir_q == DIR_UP) begin
              out_nxt = (out >= hi) ? lo : up_next;
            end else begin
              out_nxt = (out <= lo) ? hi : down_next;
            end
          end
          MODE_ONESHOT: begin
            if (dir_q == DIR_UP) begin
              if (out < hi) begin
                out_nxt = up_next;
                if (up_next == hi) done_nxt = 1'b1;
              end
            end else begin
              if (out > lo) begin
                out_nxt = down_next;
                if (down_next == lo) done_nxt = 1'b1;
              end
            end
          end
          default: begin
            out_nxt = out;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_param_ping_pong_counter.sv
// Directed and randomized checks of param_ping_pong_counter against an integer reference model.
module tb_param_ping_pong_counter;
  import ppc_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         load;
  logic [W-1:0] load_val;
  logic         load_dir;
  logic [W-1:0] lo;
  logic [W-1:0] hi;
  logic [W-1:0] step;
  logic [1:0]   mode;
  logic [W-1:0] out;
  logic         direction;
  logic         bounce;
  logic         done;
  logic         cfg_err;

  int nvec = 0;
  int nerr = 0;
  int m_out, m_dir, m_done, m_bnc;

  param_ping_pong_counter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .load      (load),
    .load_val  (load_val),
    .load_dir  (load_dir),
    .lo        (lo),
    .hi        (hi),
    .step      (step),
    .mode      (mode),
    .out       (out),
    .direction (direction),
    .bounce    (bounce),
    .done      (done),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Reference behaviour for one rising edge, in plain integer arithmetic.
  task automatic model_edge();
    int l, h, s;
    l = int'(lo); h = int'(hi); s = int'(step);
    m_bnc = 0;
    if (load) begin
      m_out = int'(load_val); m_dir = int'(load_dir); m_done = 0;
    end else if (enable && !(l > h || s == 0)) begin
      if (m_out > h) m_out = h;
      else if (m_out < l) m_out = l;
      else begin
        case (mode)
          MODE_PINGPONG:
            if (m_dir == 1) begin
              if (m_out >= h) begin m_dir = 0; m_out = imax(h - s, l); m_bnc = 1; end
              else m_out = imin(m_out + s, h);
            end else begin
              if (m_out <= l) begin m_dir = 1; m_out = imin(l + s, h); m_bnc = 1; end
              else m_out = imax(m_out - s, l);
            end
          MODE_WRAP:
            if (m_dir == 1) m_out = (m_out >= h) ? l : imin(m_out + s, h);
            else            m_out = (m_out <= l) ? h : imax(m_out - s, l);
          MODE_ONESHOT:
            if (m_dir == 1) begin
              if (m_out < h) begin m_out = imin(m_out + s, h); if (m_out == h) m_done = 1; end
            end else begin
              if (m_out > l) begin m_out = imax(m_out - s, l); if (m_out == l) m_done = 1; end
            end
          default: ;
        endcase
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out"}, 8'(out), 8'(m_out));
    chk({tag, ".dir"}, 8'(direction), 8'(m_dir));
    chk({tag, ".bounce"}, 8'(bounce), 8'(m_bnc));
    chk({tag, ".done"}, 8'(done), 8'(m_done));
    chk({tag, ".cfg_err"}, 8'(cfg_err), 8'((lo > hi) || (step == '0)));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic do_load(input int v, input int d, input string tag);
    load = 1'b1; load_val = W'(v); load_dir = d[0];
    tick(tag);
    load = 1'b0;
  endtask

  int exp21[8] = '{3, 6, 9, 10, 7, 4, 3, 6};
  int exp23[6] = '{0, 4, 8, 12, 15, 15};

  initial begin
    rst = 1'b1; enable = 1'b0; load = 1'b0; load_val = '0; load_dir = 1'b0;
    lo = 4'd0; hi = 4'd15; step = 4'd1; mode = MODE_PINGPONG;
    m_out = 0; m_dir = 1; m_done = 0; m_bnc = 0;
    #13;
    check_all("reset");
    @(negedge clk); rst = 1'b0;

    // full-range ping-pong with step 1
    enable = 1'b1;
    for (int i = 0; i < 32; i++) tick("pp_full");

    // ping-pong inside [3,10] with step 3
    lo = 4'd3; hi = 4'd10; step = 4'd3;
    do_load(3, 1, "pp_load");
    chk("pp21.out0", 8'(out), 8'(exp21[0]));
    for (int i = 1; i < 8; i++) begin
      tick("pp21");
      chk("pp21.seq", 8'(out), 8'(exp21[i]));
    end

    // wrap in [2,5], both directions
    mode = MODE_WRAP; lo = 4'd2; hi = 4'd5; step = 4'd1;
    do_load(2, 1, "wrap_up_load");
    for (int i = 0; i < 6; i++) tick("wrap_up");
    do_load(5, 0, "wrap_dn_load");
    for (int i = 0; i < 5; i++) tick("wrap_dn");

    // one-shot to 15 with step 4
    mode = MODE_ONESHOT; lo = 4'd0; hi = 4'd15; step = 4'd4;
    do_load(0, 1, "os_load");
    for (int i = 1; i < 6; i++) begin
      tick("os");
      chk("os.seq", 8'(out), 8'(exp23[i]));
    end
    chk("os.done_set", 8'(done), 8'd1);
    do_load(1, 1, "os_clear");
    chk("os.done_clr", 8'(done), 8'd0);

    // disturbances: hold, load, asynchronous reset
    mode = MODE_PINGPONG;
    do_load(9, 0, "dist_load9");
    enable = 1'b0;
    tick("dist_hold");
    chk("dist_hold.out", 8'(out), 8'd9);
    do_load(2, 1, "dist_load2");
    chk("dist_load2.out", 8'(out), 8'd2);
    enable = 1'b1;
    tick("dist_run");
    #4 rst = 1'b1;
    #1;
    chk("async_rst.out", 8'(out), 8'd0);
    chk("async_rst.dir", 8'(direction), 8'd1);
    m_out = 0; m_dir = 1; m_done = 0; m_bnc = 0;
    #1 rst = 1'b0;
    tick("after_rst");

    // configuration errors
    lo = 4'd8; hi = 4'd4;
    tick("cfg_lohi");
    tick("cfg_lohi");
    lo = 4'd0; hi = 4'd15; step = 4'd0;
    tick("cfg_step0");
    step = 4'd1;
    do_load(12, 1, "cfg_load12");
    hi = 4'd9;
    tick("cfg_clamp");
    chk("cfg_clamp.out", 8'(out), 8'd9);
    chk("cfg_clamp.bounce", 8'(bounce), 8'd0);
    for (int i = 0; i < 3; i++) tick("cfg_resume");

    // randomized traffic, including out-of-range loads and invalid configs
    for (int i = 0; i < 400; i++) begin
      enable = ($urandom_range(3) != 0);
      load   = ($urandom_range(15) == 0);
      load_val = W'($urandom);
      load_dir = 1'($urandom);
      if ($urandom_range(19) == 0) mode = 2'($urandom);
      if ($urandom_range(24) == 0) begin
        int a, b;
        a = $urandom_range(15); b = $urandom_range(15);
        if ($urandom_range(7) == 0) begin lo = W'(a); hi = W'(b); end
        else begin lo = W'(imin(a, b)); hi = W'(imax(a, b)); end
        step = ($urandom_range(9) == 0) ? 4'd0 : W'($urandom_range(1, 7));
      end
      tick("rand");
    end
    load = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
